// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE constants and the sponge controller state encoding.
package keccak_pkg;
    localparam int LANE_W        = 64;
    localparam int STATE_W       = 1600;
    localparam int NUM_LANES     = 25;
    localparam int SHAKE128_RATE = 21;
    localparam int SHAKE256_RATE = 17;

    localparam logic [7:0] SHAKE_DOMAIN = 8'h1F;
    localparam logic [7:0] PAD_END_BYTE = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_PAD,
        ST_PERM_REQ,
        ST_PERM_DROP,
        ST_SQUEEZE
    } sponge_state_e;
endpackage

// File: rtl/shake_pad.sv
// Builds the pad10*1 mask: domain byte at the pad position, 0x80 in the last rate byte.
module shake_pad
    import keccak_pkg::*;
(
    input  logic [4:0]         lane_idx,
    input  logic [2:0]         byte_pos,
    input  logic [4:0]         rate_lanes,
    input  logic [7:0]         domain_byte,
    output logic [STATE_W-1:0] pad_mask
);
    logic [10:0] dom_bit;
    logic [10:0] end_bit;

    always_comb begin
        dom_bit  = {lane_idx, 6'd0} + {5'd0, byte_pos, 3'd0};
        end_bit  = {rate_lanes, 6'd0} - 11'd8;
        pad_mask = '0;
        pad_mask[dom_bit +: 8] = domain_byte;
        // OR rather than overwrite so a coinciding position yields domain|0x80.
        pad_mask[end_bit +: 8] = pad_mask[end_bit +: 8] | PAD_END_BYTE;
    end
endmodule

// File: rtl/shake_sponge_ctrl.sv
// SHAKE sponge controller: absorbs a lane stream, pads, drives an external
// Keccak-f core through a rtr/rts handshake and squeezes out_nlanes lanes.
module shake_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int         RATE_LANES  = SHAKE128_RATE,
    parameter logic [7:0] DOMAIN_BYTE = SHAKE_DOMAIN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        out_nlanes,
    input  logic [63:0]        in_lane,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [3:0]         in_bytes,
    output logic [63:0]        out_lane,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [STATE_W-1:0] perm_A,
    output logic               perm_rtr,
    input  logic [STATE_W-1:0] perm_Aout,
    input  logic               perm_rts
);
    localparam logic [4:0] RATE_L    = 5'(RATE_LANES);
    localparam logic [4:0] RATE_LAST = RATE_L - 5'd1;

    sponge_state_e      state_q, state_d, ret_q, ret_d;
    logic [STATE_W-1:0] s_q, s_d;
    logic [4:0]         k_q, k_d, j_q, j_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [4:0]         pad_lane_q, pad_lane_d;
    logic [2:0]         pad_byte_q, pad_byte_d;
    logic [STATE_W-1:0] pad_mask;
    logic [10:0]        k_base, j_base;

    function automatic logic [63:0] lane_keep_mask(input logic [3:0] nbytes);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) begin
            m[8*b +: 8] = (b < int'(nbytes)) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

    shake_pad u_pad (
        .lane_idx   (pad_lane_q),
        .byte_pos   (pad_byte_q),
        .rate_lanes (RATE_L),
        .domain_byte(DOMAIN_BYTE),
        .pad_mask   (pad_mask)
    );

    assign k_base = {k_q, 6'd0};
    assign j_base = {j_q, 6'd0};
    assign perm_A = s_q;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        s_d        = s_q;
        k_d        = k_q;
        j_d        = j_q;
        cnt_d      = cnt_q;
        pad_lane_d = pad_lane_q;
        pad_byte_d = pad_byte_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_lane   = '0;
        perm_rtr   = 1'b0;
        busy       = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = '0;
                    k_d     = '0;
                    j_d     = '0;
                    cnt_d   = out_nlanes;
                    state_d = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                in_ready = 1'b1;
                if (in_valid && !in_last) begin
                    s_d[k_base +: 64] = s_q[k_base +: 64] ^ in_lane;
                    if (k_q == RATE_LAST) begin
                        k_d     = '0;
                        ret_d   = ST_ABSORB;
                        state_d = ST_PERM_REQ;
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end else if (in_valid) begin
                    s_d[k_base +: 64] = s_q[k_base +: 64] ^ (in_lane & lane_keep_mask(in_bytes));
                    pad_byte_d = in_bytes[3] ? 3'd0 : in_bytes[2:0];
                    if (!in_bytes[3]) begin
                        pad_lane_d = k_q;
                        state_d    = ST_PAD;
                    end else if (k_q == RATE_LAST) begin
                        // Full final lane filled the block: pad lands in a fresh block.
                        pad_lane_d = '0;
                        ret_d      = ST_PAD;
                        state_d    = ST_PERM_REQ;
                    end else begin
                        pad_lane_d = k_q + 5'd1;
                        state_d    = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                s_d     = s_q ^ pad_mask;
                j_d     = '0;
                ret_d   = ST_SQUEEZE;
                state_d = ST_PERM_REQ;
            end
            ST_PERM_REQ: begin
                perm_rtr = 1'b1;
                if (perm_rts) begin
                    s_d     = perm_Aout;
                    state_d = ST_PERM_DROP;
                end
            end
            ST_PERM_DROP: begin
                if (!perm_rts) begin
                    state_d = (ret_q == ST_SQUEEZE && cnt_q == 16'd0) ? ST_IDLE : ret_q;
                end
            end
            ST_SQUEEZE: begin
                out_valid = 1'b1;
                out_lane  = s_q[j_base +: 64];
                if (out_ready) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_IDLE;
                    end else if (j_q == RATE_LAST) begin
                        j_d     = '0;
                        ret_d   = ST_SQUEEZE;
                        state_d = ST_PERM_REQ;
                    end else begin
                        j_d = j_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            s_q        <= '0;
            k_q        <= '0;
            j_q        <= '0;
            cnt_q      <= '0;
            pad_lane_q <= '0;
            pad_byte_q <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            s_q        <= s_d;
            k_q        <= k_d;
            j_q        <= j_d;
            cnt_q      <= cnt_d;
            pad_lane_q <= pad_lane_d;
            pad_byte_q <= pad_byte_d;
        end
    end
endmodule

// File: doc/shake_sponge_ctrl.md
SHAKE_SPONGE_CTRL -- requirements
Module: shake_sponge_ctrl

Interface
REQ-001 SHALL have parameter RATE_LANES, default 21, rate in 64-bit lanes (21 = SHAKE128, 17 = SHAKE256).
REQ-002 SHALL have parameter DOMAIN_BYTE, default 8'h1F, SHAKE domain/pad-start byte.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse in IDLE begins a new hash; ignored elsewhere.
REQ-006 out_nlanes  input  16  number of squeeze lanes; latched on start.
REQ-007 in_lane / in_valid / in_ready  input 64 / input 1 / output 1  message lane stream, little-endian bytes.
REQ-008 in_last / in_bytes  input 1 / input 4  final lane flag; valid byte count 0..8 of that lane.
REQ-009 out_lane / out_valid / out_ready  output 64 / output 1 / input 1  squeezed lane stream.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 perm_A / perm_rtr  output 1600 / output 1  state and request to the permutation core.
REQ-012 perm_Aout / perm_rts  input 1600 / input 1  permuted state and completion from the permutation core.

Function
REQ-013 SHALL hold 1600-bit state S; lane i = S[64i+63:64i], i = x+5y; S is zeroed on start.
REQ-014 SHALL use FSM states IDLE, ABSORB, PAD, PERM_REQ, PERM_DROP, SQUEEZE.
REQ-015 IDLE -> ABSORB on start; in ABSORB in_ready=1, and each in_valid&&in_ready XORs in_lane into lane k, k++.
REQ-016 For a non-last lane, all 8 bytes SHALL be absorbed; for the in_last lane, only the low in_bytes bytes are absorbed, and the upper bytes are ignored.
REQ-017 After a non-last lane with k reaching RATE_LANES: -> PERM_REQ with return to ABSORB, k=0.
REQ-018 After the in_last lane: -> PAD; pad position p = byte 8k_last+in_bytes; when in_bytes=8, p lies in the next lane.
REQ-019 If p < 8*RATE_LANES, PAD SHALL XOR DOMAIN_BYTE at byte p and 8'h80 at byte 8*RATE_LANES-1 (one byte gets 8'h9F if they coincide) in one cycle.
REQ-020 If p = 8*RATE_LANES (last lane full, block full), SHALL permute first, then pad at byte 0 of a fresh block.
REQ-021 Zero-length message: start then in_last with in_bytes=0 in lane 0 -> pad at byte 0.
REQ-022 After the final pad: -> PERM_REQ with return to SQUEEZE, squeeze index j=0.
REQ-023 PERM_REQ: drive perm_A=S and perm_rtr=1, both stable, until perm_rts=1; then capture S<=perm_Aout in that cycle and -> PERM_DROP.
REQ-024 PERM_DROP: perm_rtr=0; wait for perm_rts=0, then go to the return state; no new request while perm_rts=1.
REQ-025 SQUEEZE: out_lane = lane j of S, out_valid=1; on out_ready, j++ and the remaining count decrements.
REQ-026 SHALL go to PERM_REQ when j reaches RATE_LANES and lanes remain.
REQ-027 SHALL go to IDLE when the count reaches 0; out_nlanes=0 skips SQUEEZE and goes straight to IDLE.
REQ-028 out_lane SHALL stay stable while out_valid && !out_ready.
REQ-029 in_ready SHALL be 0 outside ABSORB; out_valid SHALL be 0 outside SQUEEZE.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE and S, k, j and the count SHALL be zeroed.
REQ-031 On reset, all outputs SHALL be 0, including perm_rtr, in_ready, out_valid and busy.
REQ-032 Reset mid-permutation SHALL drop perm_rtr; the permutation core is reset from the same reset net.

Structure
REQ-033 Package keccak_pkg SHALL hold the lane width (64), the state width (1600), SHAKE128/256 rate constants, the DOMAIN_BYTE default and the FSM state enum.
REQ-034 SHALL contain one sub-module, shake_pad: combinational; takes lane index, byte position, rate and domain byte, and returns the 1600-bit pad mask.
REQ-035 The permutation core SHALL be instantiated beside this block, not inside it.

Verification
REQ-036 SHAKE128, empty message, out_nlanes=2 -> lane0 = 64'h7D828FE8A42B9C7F; exactly one permutation.
REQ-037 SHAKE128, 21 full lanes, no in_last, plus a last lane with in_bytes=0 -> two permutations; output matches the software model.
REQ-038 SHAKE128, lane 20 is last with in_bytes=8 -> extra pad-only block (REQ-020); output matches the model.
REQ-039 SHAKE128, out_nlanes=43 -> three permutations; output matches the model; out_ready randomly low holds out_lane stable.
REQ-040 Model perm_rts held high 5 cycles after capture -> no second perm_rtr rise until perm_rts=0.
REQ-041 Reset asserted in PERM_REQ and in SQUEEZE -> next cycle all outputs 0 and busy=0; the following hash is correct.
